// File: rtl/branch_ctrl.sv
// Execute-stage conditional-branch sequencer: waits for operands, resolves the
// condition, flushes on mispredict and returns the outcome over valid/ready.
module branch_ctrl #(
  parameter int DW           = 32,
  parameter int AW           = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_opcode,
  input  logic [AW-1:0] req_pc,
  input  logic [AW-1:0] req_offset,
  input  logic          req_pred,
  input  logic          ops_ready,
  input  logic [DW-1:0] rs1_data,
  input  logic [DW-1:0] rs2_data,
  input  logic          kill,
  output logic          flush,
  output logic [AW-1:0] redirect_pc,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic          resp_taken,
  output logic          resp_mispredict,
  output logic [15:0]   branch_cnt,
  output logic [15:0]   mispred_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_EVAL,
    S_FLUSH,
    S_RESP
  } state_t;

  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1010;
  localparam logic [3:0] OP_BLT  = 4'b0010;
  localparam logic [3:0] OP_BGE  = 4'b0011;
  localparam logic [3:0] OP_BGTZ = 4'b1100;
  localparam logic [3:0] OP_BGT  = 4'b1110;

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);
  localparam logic signed [DW-1:0] ZERO = '0;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t                 state;
  logic [FCW-1:0]         flush_cnt;
  logic [3:0]             op_q;
  logic [AW-1:0]          pc_q;
  logic [AW-1:0]          off_q;
  logic                   pred_q;
  logic signed [DW-1:0]   rs1_q;
  logic signed [DW-1:0]   rs2_q;

  logic                   taken_c;
  logic                   mispred_c;
  logic [AW-1:0]          target_c;

  // Direct signed relational compares; a subtract-and-test-sign would
  // misresolve when rs1 - rs2 overflows.
  // NOTE: taken_c gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    taken_c = 1'b0;
    case (op_q)
      OP_BEQ:  taken_c = (rs1_q == rs2_q);
      OP_BNE:  taken_c = (rs1_q != rs2_q);
      OP_BLT:  taken_c = (rs1_q <  rs2_q);
      OP_BGE:  taken_c = (rs1_q >= rs2_q);
      OP_BGTZ: taken_c = (rs1_q >  ZERO);
      OP_BGT:  taken_c = (rs1_q >  rs2_q);
      default: taken_c = 1'b0;
    endcase
  end

  assign mispred_c = (taken_c != pred_q);
  assign target_c  = taken_c ? (pc_q + off_q) : (pc_q + AW'(2));

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the latched operand/PC registers are reset too; they are few and a
  // defined value keeps simulation free of X on the comparator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      req_ready       <= 1'b1;
      flush           <= 1'b0;
      redirect_pc     <= '0;
      resp_valid      <= 1'b0;
      resp_taken      <= 1'b0;
      resp_mispredict <= 1'b0;
      branch_cnt      <= '0;
      mispred_cnt     <= '0;
      flush_cnt       <= '0;
      op_q            <= '0;
      pc_q            <= '0;
      off_q           <= '0;
      pred_q          <= 1'b0;
      rs1_q           <= '0;
      rs2_q           <= '0;
    end else if (kill) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      flush      <= 1'b0;
      resp_valid <= 1'b0;
      flush_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q      <= req_opcode;
            pc_q      <= req_pc;
            off_q     <= req_offset;
            pred_q    <= req_pred;
            req_ready <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ops_ready) begin
            rs1_q <= rs1_data;
            rs2_q <= rs2_data;
            state <= S_EVAL;
          end
        end
        S_EVAL: begin
          resp_taken      <= taken_c;
          resp_mispredict <= mispred_c;
          if (branch_cnt != CNT_MAX) branch_cnt <= branch_cnt + 16'd1;
          if (mispred_c) begin
            if (mispred_cnt != CNT_MAX) mispred_cnt <= mispred_cnt + 16'd1;
            flush       <= 1'b1;
            redirect_pc <= target_c;
            flush_cnt   <= FLUSH_LOAD;
            state       <= S_FLUSH;
          end else begin
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_FLUSH: begin
          if (flush_cnt == '0) begin
            flush      <= 1'b0;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else begin
            flush_cnt <= flush_cnt - FCW'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed corner cases plus randomized
// branches checked against a behavioural model of the resolution rules.
module tb_branch_ctrl;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int FC = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_opcode;
  logic [AW-1:0] req_pc;
  logic [AW-1:0] req_offset;
  logic          req_pred;
  logic          ops_ready;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic          kill;
  logic          flush;
  logic [AW-1:0] redirect_pc;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_taken;
  logic          resp_mispredict;
  logic [15:0]   branch_cnt;
  logic [15:0]   mispred_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_bc   = 0;
  int exp_mc   = 0;

  branch_ctrl #(.DW(DW), .AW(AW), .FLUSH_CYCLES(FC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_opcode      (req_opcode),
    .req_pc          (req_pc),
    .req_offset      (req_offset),
    .req_pred        (req_pred),
    .ops_ready       (ops_ready),
    .rs1_data        (rs1_data),
    .rs2_data        (rs2_data),
    .kill            (kill),
    .flush           (flush),
    .redirect_pc     (redirect_pc),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_taken      (resp_taken),
    .resp_mispredict (resp_mispredict),
    .branch_cnt      (branch_cnt),
    .mispred_cnt     (mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: operands as signed integers, plain relational compares.
  function automatic bit ref_taken(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    case (op)
      4'b1000: return sa == sb;
      4'b1010: return sa != sb;
      4'b0010: return sa <  sb;
      4'b0011: return sa >= sb;
      4'b1100: return sa >  0;
      4'b1110: return sa >  sb;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] ref_target(input bit t, input logic [15:0] pc, input logic [15:0] off);
    int p = pc;
    int o = $signed(off);
    int r = t ? (p + o) : (p + 2);
    return r[15:0];
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic check_counters(input string tag);
    check({tag, ":branch_cnt"}, 32'(branch_cnt), 32'(exp_bc));
    check({tag, ":mispred_cnt"}, 32'(mispred_cnt), 32'(exp_mc));
  endtask

  // Presents a request in cycle N; returns at the negedge of cycle N+1 (WAIT).
  task automatic start_req(input string tag, input logic [3:0] op, input logic [15:0] pc,
                           input logic [15:0] off, input logic pred);
    check({tag, ":req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_opcode = op; req_pc = pc; req_offset = off; req_pred = pred;
    @(negedge clk);
    req_valid = 1'b0; req_opcode = 4'($urandom); req_pc = 16'($urandom);
    req_offset = 16'($urandom); req_pred = 1'($urandom);
  endtask

  // Presents operands for one cycle; returns at the negedge of the EVAL cycle.
  task automatic feed_ops(input logic [31:0] a, input logic [31:0] b);
    ops_ready = 1'b1; rs1_data = a; rs2_data = b;
    @(negedge clk);
    ops_ready = 1'b0; rs1_data = $urandom; rs2_data = $urandom;
  endtask

  task automatic run_branch(input string tag, input logic [3:0] op, input logic [15:0] pc,
                            input logic [15:0] off, input logic pred, input logic [31:0] a,
                            input logic [31:0] b, input int ops_dly, input int rdy_dly);
    bit          exp_t = ref_taken(op, a, b);
    bit          exp_m = (exp_t != pred);
    logic [15:0] exp_pc = ref_target(exp_t, pc, off);
    start_req(tag, op, pc, off, pred);
    for (int i = 0; i < ops_dly; i++) begin
      check({tag, ":wait_quiet"}, {29'd0, req_ready, flush, resp_valid}, 32'd0);
      @(negedge clk);
    end
    check({tag, ":wait_quiet"}, {29'd0, req_ready, flush, resp_valid}, 32'd0);
    feed_ops(a, b);
    check({tag, ":eval_quiet"}, {29'd0, req_ready, flush, resp_valid}, 32'd0);
    @(negedge clk);
    exp_bc = sat_inc(exp_bc);
    if (exp_m) exp_mc = sat_inc(exp_mc);
    if (exp_m) begin
      for (int i = 0; i < FC; i++) begin
        check({tag, ":flush"}, {30'd0, flush, resp_valid}, 32'b10);
        check({tag, ":redirect_pc"}, 32'(redirect_pc), 32'(exp_pc));
        @(negedge clk);
      end
    end
    check({tag, ":resp_valid"}, {29'd0, resp_valid, flush, req_ready}, 32'b100);
    check({tag, ":resp_taken"}, 32'(resp_taken), 32'(exp_t));
    check({tag, ":resp_mispredict"}, 32'(resp_mispredict), 32'(exp_m));
    check_counters(tag);
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      check({tag, ":resp_hold"}, {29'd0, resp_valid, resp_taken, resp_mispredict},
            {29'd0, 1'b1, exp_t, exp_m});
      check({tag, ":req_ready_busy"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, ":after_handshake"}, {30'd0, resp_valid, req_ready}, 32'b01);
  endtask

  initial begin
    logic [3:0]  ops_tab [7] = '{4'b1000, 4'b1010, 4'b0010, 4'b0011, 4'b1100, 4'b1110, 4'b0000};
    logic [31:0] edge_tab[5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    rst_n = 1'b0; req_valid = 1'b0; req_opcode = '0; req_pc = '0; req_offset = '0;
    req_pred = 1'b0; ops_ready = 1'b0; rs1_data = '0; rs2_data = '0; kill = 1'b0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset:ctrl", {28'd0, req_ready, flush, resp_valid, resp_taken}, 32'b1000);
    check("reset:redirect_pc", 32'(redirect_pc), 32'd0);
    check_counters("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Signed compare across sign boundary, mispredict with flush.
    run_branch("blt_neg", 4'b0010, 16'h0100, 16'h0020, 1'b0, 32'hFFFF_FFFF, 32'h1, 0, 0);
    check("blt_neg:mispred_cnt_is_1", 32'(mispred_cnt), 32'd1);
    // Overflowing difference must not flip the result.
    run_branch("bge_ovf", 4'b0011, 16'h0200, 16'h0010, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 0, 0);
    run_branch("beq_stall", 4'b1000, 16'h0300, 16'h0040, 1'b1, 32'h1234_5678, 32'h1234_5678, 0, 4);
    run_branch("bne_wrap", 4'b1010, 16'hFFFE, 16'h0004, 1'b0, 32'h5, 32'h6, 0, 0);
    run_branch("bne_nt_wrap", 4'b1010, 16'hFFFE, 16'h0004, 1'b1, 32'h5, 32'h5, 0, 0);
    run_branch("bgt_slow_ops", 4'b1110, 16'h0400, 16'hFFF0, 1'b1, 32'h10, 32'h2, 10, 0);
    run_branch("bgtz_neg_off", 4'b1100, 16'h0010, 16'hFFE0, 1'b0, 32'h1, 32'h0, 1, 1);
    run_branch("op0000", 4'b0000, 16'h0500, 16'h0008, 1'b1, 32'h7, 32'h7, 0, 0);

    // kill in WAIT: back to IDLE, stray ops_ready ignored.
    start_req("kill_wait", 4'b1000, 16'h0600, 16'h0004, 1'b0);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_wait:state", {29'd0, req_ready, flush, resp_valid}, 32'b100);
    check_counters("kill_wait");
    ops_ready = 1'b1;
    @(negedge clk);
    ops_ready = 1'b0;
    @(negedge clk);
    check("kill_wait:idle_kept", {29'd0, req_ready, flush, resp_valid}, 32'b100);

    // kill in the second FLUSH cycle.
    start_req("kill_flush", 4'b0010, 16'h0700, 16'h0020, 1'b0);
    feed_ops(32'hFFFF_FFFE, 32'h3);
    @(negedge clk);
    exp_bc = sat_inc(exp_bc);
    exp_mc = sat_inc(exp_mc);
    check("kill_flush:flush1", 32'(flush), 32'd1);
    @(negedge clk);
    check("kill_flush:flush2", 32'(flush), 32'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_flush:state", {29'd0, req_ready, flush, resp_valid}, 32'b100);
    check_counters("kill_flush");
    repeat (3) begin
      @(negedge clk);
      check("kill_flush:no_resp", {29'd0, req_ready, flush, resp_valid}, 32'b100);
    end

    // kill in IDLE blocks acceptance.
    kill = 1'b1; req_valid = 1'b1; req_opcode = 4'b1000;
    @(negedge clk);
    kill = 1'b0; req_valid = 1'b0;
    check("kill_idle:not_accepted", 32'(req_ready), 32'd1);
    @(negedge clk);
    check("kill_idle:still_idle", {29'd0, req_ready, flush, resp_valid}, 32'b100);

    // Randomized branches against the model.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? edge_tab[$urandom_range(0, 4)] : $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = edge_tab[$urandom_range(0, 4)];
        default: b = $urandom;
      endcase
      run_branch("rand", ($urandom_range(0, 5) == 0) ? 4'($urandom) : ops_tab[$urandom_range(0, 6)],
                 16'($urandom), 16'($urandom), 1'($urandom), a, b,
                 $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Counter saturation from a preloaded near-full value.
    force dut.branch_cnt = 16'hFFFE;
    force dut.mispred_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.branch_cnt;
    release dut.mispred_cnt;
    exp_bc = 16'hFFFE;
    exp_mc = 16'hFFFE;
    @(negedge clk);
    check_counters("sat_preload");
    run_branch("sat1", 4'b1010, 16'h0800, 16'h0010, 1'b0, 32'h1, 32'h2, 0, 0);
    run_branch("sat2", 4'b1010, 16'h0900, 16'h0010, 1'b0, 32'h3, 32'h4, 0, 0);
    check("sat:branch_cnt_max", 32'(branch_cnt), 32'hFFFF);

    // Async reset mid-FLUSH.
    start_req("rst_flush", 4'b1110, 16'h0A00, 16'h0030, 1'b0);
    feed_ops(32'h9, 32'h2);
    @(negedge clk);
    check("rst_flush:in_flush", 32'(flush), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    exp_bc = 0;
    exp_mc = 0;
    check("rst_flush:ctrl", {28'd0, req_ready, flush, resp_valid, resp_taken}, 32'b1000);
    check("rst_flush:mispredict", 32'(resp_mispredict), 32'd0);
    check("rst_flush:redirect_pc", 32'(redirect_pc), 32'd0);
    check_counters("rst_flush");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_flush:no_resp", {29'd0, req_ready, flush, resp_valid}, 32'b100);
    end
    run_branch("post_rst", 4'b0011, 16'h0B00, 16'h0008, 1'b1, 32'h5, 32'h5, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
